booth_dot_accumulator: RTL and testbench
========================================

BOOTH_DOT_ACCUMULATOR -- requirements
Module: booth_dot_accumulator

Interface
REQ-001 Parameter TERMS, default 4, number of products summed per accumulation; legal range is 1 to 15.
REQ-002 Parameter ACC_W, default 12, accumulator width in bits; legal range is 8 to 16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  request to begin a new accumulation; sampled only in IDLE, or in DONE together with out_ack.
REQ-006 prod_valid  input  1  upstream multiplier presents a finished product.
REQ-007 prod_in  input  8  product from the multiplier, two's-complement signed.
REQ-008 prod_ready  output  1  block accepts a product this cycle.
REQ-009 out_ack  input  1  consumer takes the result.
REQ-010 acc_out  output  ACC_W  signed accumulated sum.
REQ-011 acc_valid  output  1  acc_out holds a final result.
REQ-012 busy  output  1  high while in ACCUM.
REQ-013 overflow  output  1  sticky flag: saturation occurred in the current accumulation.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE; encoding is free.
REQ-015 In IDLE with start=1, next state SHALL be ACCUM, with acc_out, the term counter and overflow cleared to 0.
REQ-016 In IDLE with start=0, the block SHALL stay in IDLE and hold acc_out and overflow.
REQ-017 prod_ready SHALL equal 1 only in ACCUM.
REQ-018 A transfer occurs when prod_valid=1 and prod_ready=1 on the same edge; a product SHALL be added exactly once per transfer.
REQ-019 prod_valid without prod_ready SHALL have no effect.
REQ-020 Addition: prod_in is sign-extended to ACC_W+1 bits and added to the sign-extended acc_out.
REQ-021 If the sum exceeds 2^(ACC_W-1)-1, acc_out SHALL clamp to that maximum and overflow SHALL set.
REQ-022 If the sum is below -2^(ACC_W-1), acc_out SHALL clamp to that minimum and overflow SHALL set.
REQ-023 A saturated accumulator SHALL continue accumulating from the clamped value, with no wrap-around.
REQ-024 The term counter SHALL be ceil(log2(TERMS+1)) bits wide and increment on each transfer.
REQ-025 On the transfer that makes the count equal TERMS, next state SHALL be DONE.
REQ-026 acc_valid SHALL be high the cycle after the final transfer, which gives a latency of 1 cycle.
REQ-027 acc_valid SHALL equal 1 only in DONE; acc_out and overflow SHALL hold stable there.
REQ-028 In DONE with out_ack=0, the block SHALL stay in DONE indefinitely.
REQ-029 In DONE with out_ack=1 and start=0, next state SHALL be IDLE; acc_out and overflow SHALL be retained.
REQ-030 In DONE with out_ack=1 and start=1, next state SHALL be ACCUM directly, with acc_out, the counter and overflow cleared.
REQ-031 start SHALL be ignored in ACCUM; an accumulation cannot be restarted or aborted except by reset.
REQ-032 out_ack outside DONE SHALL be ignored.
REQ-033 busy SHALL equal 1 only in ACCUM.

Reset
REQ-034 When reset=0 at a rising edge, the state SHALL become IDLE; acc_out, the counter and overflow SHALL become 0; acc_valid, busy and prod_ready SHALL be 0 from the following cycle.
REQ-035 Reset SHALL take priority over every other input in every state, including mid-accumulation; a partial sum SHALL be discarded.

Structure
REQ-036 The shared package SHALL hold the state enumeration, PROD_W=8, and the saturation limit helper functions for ACC_W.
REQ-037 One sub-module, booth_sat_add (a signed saturating adder, combinational, parameterised on widths), SHALL perform REQ-020 to REQ-022; everything else stays in booth_dot_accumulator.

Verification
REQ-038 TERMS=4, ACC_W=12: start, then products 12, -6, 64, -56, one per cycle -> acc_out=14, overflow=0; acc_valid rises 1 cycle after the 4th transfer.
REQ-039 Products 5, 5, 5, 5 with prod_valid toggled 1,0,1,0,... -> only the 4 handshaken products count; acc_out=20.
REQ-040 ACC_W=8: products 64, 64, 64, -56 -> saturates at 127 after the 2nd product, then 127, then 71; overflow=1 in DONE.
REQ-041 In DONE, hold out_ack=0 for 5 cycles, then assert out_ack=1 together with start=1 -> acc_valid held throughout; the next cycle is ACCUM with acc_out=0 and overflow=0.
REQ-042 Reset=0 applied after 2 of 4 transfers -> next cycle IDLE, acc_out=0; a later start runs a full 4-term accumulation correctly.
REQ-043 start pulsed during ACCUM and out_ack pulsed in IDLE -> no state, counter or accumulator change.

Source files
------------

// File: rtl/booth_dot_accumulator_pkg.sv
// booth_dot_accumulator_pkg: shared state encoding, product width and saturation limits
package booth_dot_accumulator_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int PROD_W = 8;
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction
endpackage

// File: rtl/booth_sat_add.sv
// booth_sat_add: signed saturating adder, clamps a+b to the range of an A_W-bit signed value
module booth_sat_add
    import booth_dot_accumulator_pkg::*;
#(
    parameter int A_W = 12,
    parameter int B_W = 8
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           sat
);
    localparam int MAX_I = sat_max(A_W);
    localparam int MIN_I = sat_min(A_W);
    localparam logic [A_W-1:0] MAX = MAX_I[A_W-1:0];
    localparam logic [A_W-1:0] MIN = MIN_I[A_W-1:0];
    logic [A_W:0] wide;
    always_comb begin
        wide = {a[A_W-1], a} + {{(A_W + 1 - B_W){b[B_W-1]}}, b};
        sat  = wide[A_W] != wide[A_W-1];
        sum  = !sat ? wide[A_W-1:0] : wide[A_W] ? MIN : MAX;
    end
endmodule

// File: rtl/booth_dot_accumulator.sv
// booth_dot_accumulator: sums TERMS handshaken signed products with saturation, holds result until acked
module booth_dot_accumulator
    import booth_dot_accumulator_pkg::*;
#(
    parameter int TERMS = 4,
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_in,
    output logic              prod_ready,
    input  logic              out_ack,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              busy,
    output logic              overflow
);
    localparam int CNT_W = $clog2(TERMS + 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum;
    logic sat, xfer, clear, last;
    booth_sat_add #(.A_W(ACC_W), .B_W(PROD_W)) u_add (
        .a  (acc_out),
        .b  (prod_in),
        .sum(sum),
        .sat(sat)
    );
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        xfer  = state == ACCUM && prod_valid;
        last  = xfer && cnt == CNT_W'(TERMS - 1);
        // a new run may start from IDLE, or straight from DONE when the result is taken
        clear = start && (state == IDLE || (state == DONE && out_ack));
        state_nx = state == IDLE  ? (start ? ACCUM : IDLE) :
                   state == ACCUM ? (last ? DONE : ACCUM) :
                   out_ack        ? (start ? ACCUM : IDLE) : DONE;
    end
    always_comb begin
        busy       = state == ACCUM;
        prod_ready = state == ACCUM;
        acc_valid  = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            acc_out  <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (xfer) begin
            acc_out  <= sum;
            cnt      <= cnt + CNT_W'(1);
            overflow <= overflow | sat;
        end
    end
endmodule

// File: tb/tb_booth_dot_accumulator.sv
// tb_booth_dot_accumulator: directed vectors against a 12-bit and an 8-bit accumulator sharing stimulus
module tb_booth_dot_accumulator;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, prod_valid = 1'b0, out_ack = 1'b0;
    logic [7:0] prod_in = '0;
    logic prod_ready, acc_valid, busy, overflow;
    logic [11:0] acc_out;
    logic prod_ready8, acc_valid8, busy8, overflow8;
    logic [7:0] acc_out8;
    int total = 0, passed = 0;

    booth_dot_accumulator #(.TERMS(4), .ACC_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .prod_valid(prod_valid), .prod_in(prod_in),
        .prod_ready(prod_ready), .out_ack(out_ack), .acc_out(acc_out), .acc_valid(acc_valid),
        .busy(busy), .overflow(overflow)
    );
    booth_dot_accumulator #(.TERMS(4), .ACC_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .prod_valid(prod_valid), .prod_in(prod_in),
        .prod_ready(prod_ready8), .out_ack(out_ack), .acc_out(acc_out8), .acc_valid(acc_valid8),
        .busy(busy8), .overflow(overflow8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input logic signed [7:0] p);
        prod_valid = 1'b1;
        prod_in    = p;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b1;
        check("rst_valid", acc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", prod_ready, 0);
        check("rst_acc", $signed(acc_out), 0);
        check("rst_ovf", overflow, 0);

        // basic dot product
        go();
        check("t1_busy", busy, 1);
        check("t1_ready", prod_ready, 1);
        push(12); push(-6); push(64);
        check("t1_valid_early", acc_valid, 0);
        push(-56);
        check("t1_valid", acc_valid, 1);
        check("t1_acc", $signed(acc_out), 14);
        check("t1_ovf", overflow, 0);
        check("t1_busy_done", busy, 0);
        push(5);
        check("t1_done_hold", $signed(acc_out), 14);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("t1_idle_valid", acc_valid, 0);
        check("t1_idle_acc", $signed(acc_out), 14);

        // toggled valid: only handshaken products count
        go();
        for (int i = 0; i < 8; i++) begin
            prod_valid = (i % 2) == 0;
            prod_in    = 8'd5;
            tick();
        end
        prod_valid = 1'b0;
        check("t2_valid", acc_valid, 1);
        check("t2_acc", $signed(acc_out), 20);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;

        // saturation on the 8-bit instance
        go();
        push(64);
        check("t3_acc8_1", $signed(acc_out8), 64);
        check("t3_ovf8_1", overflow8, 0);
        push(64);
        check("t3_acc8_2", $signed(acc_out8), 127);
        check("t3_ovf8_2", overflow8, 1);
        push(64);
        check("t3_acc8_3", $signed(acc_out8), 127);
        push(-56);
        check("t3_acc8_4", $signed(acc_out8), 71);
        check("t3_ovf8", overflow8, 1);
        check("t3_valid8", acc_valid8, 1);
        check("t3_acc12", $signed(acc_out), 136);
        check("t3_ovf12", overflow, 0);

        // hold in DONE, then ack with restart
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", acc_valid8, 1);
        end
        check("t4_hold_acc8", $signed(acc_out8), 71);
        out_ack = 1'b1;
        start   = 1'b1;
        tick();
        out_ack = 1'b0;
        start   = 1'b0;
        check("t4_busy", busy8, 1);
        check("t4_valid", acc_valid8, 0);
        check("t4_acc8", $signed(acc_out8), 0);
        check("t4_ovf8", overflow8, 0);

        // start ignored in ACCUM, out_ack ignored in IDLE
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_busy_a", busy, 1);
        check("t5_acc_a", $signed(acc_out), 0);
        push(10); push(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_acc_b", $signed(acc_out), 30);
        check("t5_busy_b", busy, 1);
        push(1);
        check("t5_valid_early", acc_valid, 0);
        push(2);
        check("t5_valid", acc_valid, 1);
        check("t5_acc", $signed(acc_out), 33);
        out_ack = 1'b1;
        tick();
        check("t5_idle", busy, 0);
        tick();
        out_ack = 1'b0;
        check("t5_ack_idle_valid", acc_valid, 0);
        check("t5_ack_idle_busy", busy, 0);
        check("t5_ack_idle_acc", $signed(acc_out), 33);

        // reset mid-accumulation discards the partial sum
        go();
        push(7); push(8);
        check("t6_partial", $signed(acc_out), 15);
        reset      = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 8'd9;
        tick();
        reset      = 1'b1;
        prod_valid = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_acc", $signed(acc_out), 0);
        check("t6_valid", acc_valid, 0);
        go();
        push(1); push(2); push(3);
        check("t6_valid_early", acc_valid, 0);
        push(4);
        check("t6_valid_final", acc_valid, 1);
        check("t6_acc_final", $signed(acc_out), 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
